// File: rtl/paddle_input.sv
// Paddle position from up/down buttons (IDLE/SLOW/FAST acceleration), updated once per frame.
// Define PADDLE_ANALOG_EN to compile in the slew-limited analog stick path.
module paddle_input #(
   parameter logic [7:0] VPOS_MIN     = 8'd0,
   parameter logic [7:0] VPOS_MAX     = 8'd223,
   parameter logic [7:0] SPEED_SLOW   = 8'd2,
   parameter logic [7:0] SPEED_FAST   = 8'd6,
   parameter int         ACCEL_FRAMES = 8
) (
   input  logic       clk,
   input  logic       _reset,
   input  logic       vblank,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       use_analog,
   input  logic [7:0] analog_val,
   output logic [7:0] paddle_vpos,
   output logic       moved
);

   typedef enum logic [1:0] {IDLE = 2'd0, SLOW = 2'd1, FAST = 2'd2} state_t;
   typedef enum logic [1:0] {DIR_NONE = 2'd0, DIR_UP = 2'd1, DIR_DOWN = 2'd2} dir_t;

   localparam logic [8:0] POS_SUM   = {1'b0, VPOS_MIN} + {1'b0, VPOS_MAX};
   localparam logic [7:0] RESET_POS = POS_SUM[8:1];
   localparam logic [7:0] ACCEL_N   = ACCEL_FRAMES[7:0];

   logic       up_meta_r, up_sync_r, down_meta_r, down_sync_r;
   logic       vblank_d_r, armed_r, strobe_r;
   state_t     state_r, state_nx_s;
   dir_t       dir_r, dir_nx_s, dir_s;
   logic [7:0] cnt_r, cnt_nx_s;
   logic [8:0] cnt_inc_s;
   logic [7:0] pos_r, pos_nx_s;
   logic       moved_r;
   logic       analog_en_s;
   logic [7:0] analog_pos_s;

   // 9-bit step with saturation into [VPOS_MIN, VPOS_MAX]; bit 8 of the difference is the borrow.
   function automatic logic [7:0] step_pos(input logic [7:0] pos, input logic [7:0] step,
                                           input logic up);
      logic [8:0] sum;
      if (up) begin
         sum = {1'b0, pos} - {1'b0, step};
         if (sum[8] || (sum[7:0] < VPOS_MIN)) step_pos = VPOS_MIN;
         else                                 step_pos = sum[7:0];
      end else begin
         sum = {1'b0, pos} + {1'b0, step};
         if (sum > {1'b0, VPOS_MAX}) step_pos = VPOS_MAX;
         else                        step_pos = sum[7:0];
      end
   endfunction

   // Button synchronizers and vblank rising-edge strobe; armed_r blocks a strobe until vblank has been low.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         up_meta_r   <= 1'b0;
         up_sync_r   <= 1'b0;
         down_meta_r <= 1'b0;
         down_sync_r <= 1'b0;
         vblank_d_r  <= 1'b0;
         armed_r     <= 1'b0;
         strobe_r    <= 1'b0;
      end else begin
         up_meta_r   <= btn_up;
         up_sync_r   <= up_meta_r;
         down_meta_r <= btn_down;
         down_sync_r <= down_meta_r;
         vblank_d_r  <= vblank;
         armed_r     <= armed_r | ~vblank;
         strobe_r    <= vblank & ~vblank_d_r & armed_r;
      end
   end

   // Direction from the synchronized buttons; both pressed cancels out.
   always_comb begin
      dir_s = DIR_NONE;
      if (up_sync_r && !down_sync_r)      dir_s = DIR_UP;
      else if (down_sync_r && !up_sync_r) dir_s = DIR_DOWN;
      else                                dir_s = DIR_NONE;
   end

`ifdef PADDLE_ANALOG_EN
   logic [7:0] target_raw_s, target_s, gap_s, slew_s;

   assign analog_en_s = use_analog;

   // Analog target in offset binary, clamped, approached by at most SPEED_FAST per frame.
   always_comb begin
      target_raw_s = analog_val ^ 8'h80;
      target_s     = target_raw_s;
      gap_s        = 8'd0;
      slew_s       = 8'd0;
      analog_pos_s = pos_r;
      if (target_raw_s > VPOS_MAX)      target_s = VPOS_MAX;
      else if (target_raw_s < VPOS_MIN) target_s = VPOS_MIN;
      else                              target_s = target_raw_s;
      if (target_s > pos_r) gap_s = target_s - pos_r;
      else                  gap_s = pos_r - target_s;
      if (gap_s > SPEED_FAST) slew_s = SPEED_FAST;
      else                    slew_s = gap_s;
      if (target_s > pos_r) analog_pos_s = pos_r + slew_s;
      else                  analog_pos_s = pos_r - slew_s;
   end
`else
   logic unused_analog_s;

   assign analog_en_s     = 1'b0;
   assign analog_pos_s    = pos_r;
   assign unused_analog_s = ^{use_analog, analog_val};
`endif

   // Per-frame next state, hold counter, direction memory and position.
   always_comb begin
      state_nx_s = state_r;
      dir_nx_s   = dir_r;
      cnt_nx_s   = cnt_r;
      pos_nx_s   = pos_r;
      cnt_inc_s  = {1'b0, cnt_r} + 9'd1;
      if (strobe_r) begin
         if (analog_en_s) begin
            state_nx_s = IDLE;
            dir_nx_s   = DIR_NONE;
            cnt_nx_s   = 8'd0;
            pos_nx_s   = analog_pos_s;
         end else if (dir_s == DIR_NONE) begin
            state_nx_s = IDLE;
            dir_nx_s   = DIR_NONE;
            cnt_nx_s   = 8'd0;
         end else begin
            dir_nx_s = dir_s;
            case (state_r)
               SLOW: begin
                  pos_nx_s = step_pos(pos_r, SPEED_SLOW, dir_s == DIR_UP);
                  if (dir_s != dir_r) begin
                     cnt_nx_s = 8'd1;
                  end else if (cnt_inc_s >= {1'b0, ACCEL_N}) begin
                     state_nx_s = FAST;
                     cnt_nx_s   = ACCEL_N;
                  end else begin
                     cnt_nx_s = cnt_inc_s[7:0];
                  end
               end
               FAST: begin
                  if (dir_s == dir_r) begin
                     pos_nx_s = step_pos(pos_r, SPEED_FAST, dir_s == DIR_UP);
                  end else begin
                     state_nx_s = SLOW;
                     cnt_nx_s   = 8'd1;
                     pos_nx_s   = step_pos(pos_r, SPEED_SLOW, dir_s == DIR_UP);
                  end
               end
               default: begin
                  state_nx_s = SLOW;
                  cnt_nx_s   = 8'd1;
                  pos_nx_s   = step_pos(pos_r, SPEED_SLOW, dir_s == DIR_UP);
               end
            endcase
         end
      end else begin
         pos_nx_s = pos_r;
      end
   end

   // State, position and the one-cycle moved pulse.
   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         state_r <= IDLE;
         dir_r   <= DIR_NONE;
         cnt_r   <= 8'd0;
         pos_r   <= RESET_POS;
         moved_r <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         dir_r   <= dir_nx_s;
         cnt_r   <= cnt_nx_s;
         pos_r   <= pos_nx_s;
         moved_r <= strobe_r && (pos_nx_s != pos_r);
      end
   end

   assign paddle_vpos = pos_r;
   assign moved       = moved_r;

endmodule

// File: tb/tb_paddle_input.sv
// Directed scoreboard bench for paddle_input; analog scenarios run when PADDLE_ANALOG_EN is defined.
module tb_paddle_input;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       vblank;
   logic       btn_up;
   logic       btn_down;
   logic       use_analog;
   logic [7:0] analog_val;
   logic [7:0] paddle_vpos;
   logic       moved;

   int         n_checks = 0;
   int         n_pass   = 0;
   int         n_fail   = 0;
   logic [7:0] exp_pos_q[$];
   logic       exp_mv_q[$];

   paddle_input dut (
      .clk         (clk),
      ._reset      (rst_n),
      .vblank      (vblank),
      .btn_up      (btn_up),
      .btn_down    (btn_down),
      .use_analog  (use_analog),
      .analog_val  (analog_val),
      .paddle_vpos (paddle_vpos),
      .moved       (moved)
   );

   always #5 clk = ~clk;

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One frame: vblank low gap, rising edge, then compare the update two clocks later.
   task automatic frame(input bit chk, input logic [7:0] exp_pos, input logic exp_mv);
      logic [7:0] p;
      logic       m;
      repeat (4) @(negedge clk);
      vblank = 1'b1;
      if (chk) begin
         exp_pos_q.push_back(exp_pos);
         exp_mv_q.push_back(exp_mv);
      end
      @(negedge clk);
      @(negedge clk);
      if (chk) begin
         p = exp_pos_q.pop_front();
         m = exp_mv_q.pop_front();
         check8("vpos", paddle_vpos, p);
         check8("moved", {7'd0, moved}, {7'd0, m});
      end
      @(negedge clk);
      if (chk) check8("moved_pulse_end", {7'd0, moved}, 8'd0);
      vblank = 1'b0;
   endtask

   initial begin
      int e;
      rst_n      = 1'b0;
      vblank     = 1'b0;
      btn_up     = 1'b0;
      btn_down   = 1'b0;
      use_analog = 1'b0;
      analog_val = 8'h00;
      repeat (3) @(negedge clk);
      check8("reset_vpos", paddle_vpos, 8'd111);
      check8("reset_moved", {7'd0, moved}, 8'd0);
      rst_n = 1'b1;

      for (int k = 0; k < 5; k++) frame(1'b1, 8'd111, 1'b0);

      btn_down = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         e = (k <= 8) ? (111 + 2 * k) : (127 + 6 * (k - 8));
         frame(1'b1, e[7:0], 1'b1);
      end

      btn_down = 1'b0;
      btn_up   = 1'b1;
      frame(1'b1, 8'd149, 1'b1);
      frame(1'b1, 8'd147, 1'b1);
      btn_down = 1'b1;
      for (int k = 0; k < 3; k++) frame(1'b1, 8'd147, 1'b0);
      btn_down = 1'b0;
      frame(1'b1, 8'd145, 1'b1);

      for (int k = 0; k < 40; k++) frame(1'b0, 8'd0, 1'b0);
      check8("floor_reached", paddle_vpos, 8'd0);
      btn_up = 1'b0;
      frame(1'b1, 8'd0, 1'b0);
      btn_down = 1'b1;
      frame(1'b1, 8'd2, 1'b1);
      frame(1'b1, 8'd4, 1'b1);
      btn_down = 1'b0;
      frame(1'b1, 8'd4, 1'b0);
      btn_up = 1'b1;
      frame(1'b1, 8'd2, 1'b1);
      frame(1'b1, 8'd0, 1'b1);
      frame(1'b1, 8'd0, 1'b0);

      btn_up   = 1'b0;
      btn_down = 1'b1;
      frame(1'b1, 8'd2, 1'b1);
      btn_down = 1'b0;
      frame(1'b1, 8'd2, 1'b0);
      btn_down = 1'b1;
      for (int k = 0; k < 35; k++) frame(1'b0, 8'd0, 1'b0);
      check8("fast_at_180", paddle_vpos, 8'd180);
      @(negedge clk);
      vblank = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check8("async_reset_vpos", paddle_vpos, 8'd111);
      check8("async_reset_moved", {7'd0, moved}, 8'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check8("no_strobe_vblank_high", paddle_vpos, 8'd111);
      check8("no_strobe_moved", {7'd0, moved}, 8'd0);
      vblank = 1'b0;
      frame(1'b1, 8'd113, 1'b1);

      btn_down = 1'b0;
      frame(1'b1, 8'd113, 1'b0);
      btn_up = 1'b1;
      for (int k = 0; k < 30; k++) frame(1'b0, 8'd0, 1'b0);
      check8("floor_again", paddle_vpos, 8'd0);
      btn_up = 1'b0;
      frame(1'b1, 8'd0, 1'b0);
      btn_down = 1'b1;
      for (int k = 0; k < 42; k++) frame(1'b0, 8'd0, 1'b0);
      check8("at_220", paddle_vpos, 8'd220);
      btn_down = 1'b0;
      frame(1'b1, 8'd220, 1'b0);
      btn_down = 1'b1;
      frame(1'b1, 8'd222, 1'b1);
      frame(1'b1, 8'd223, 1'b1);
      frame(1'b1, 8'd223, 1'b0);

      btn_down   = 1'b0;
      btn_up     = 1'b1;
      use_analog = 1'b1;
      analog_val = 8'h7F;
`ifdef PADDLE_ANALOG_EN
      frame(1'b1, 8'd223, 1'b0);
      btn_up = 1'b0;
      rst_n  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         e = 111 + 6 * k;
         if (e > 223) e = 223;
         frame(1'b1, e[7:0], 1'b1);
      end
      frame(1'b1, 8'd223, 1'b0);
      analog_val = 8'h80;
      btn_down   = 1'b1;
      frame(1'b1, 8'd217, 1'b1);
      frame(1'b1, 8'd211, 1'b1);
      use_analog = 1'b0;
      frame(1'b1, 8'd213, 1'b1);
`else
      frame(1'b1, 8'd221, 1'b1);
      analog_val = 8'h80;
      frame(1'b1, 8'd219, 1'b1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
